// File: rtl/ad_perfect_shuffle_stream.sv
// Streaming perfect-shuffle / unshuffle word permuter with a two-entry skid buffer.
// The permutation is combinational on the input side; storage only holds reordered beats.
`timescale 1ns/1ps
module ad_perfect_shuffle_stream #(
  parameter int NUM_GROUPS      = 1,
  parameter int WORDS_PER_GROUP = 1,
  parameter int WORD_WIDTH      = 1,
  localparam int DW = NUM_GROUPS * WORDS_PER_GROUP * WORD_WIDTH
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic [1:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  // Handshake: a beat moves on a port in any cycle where valid and ready are both 1.
  localparam logic [1:0] MODE_SHUFFLE   = 2'd1;
  localparam logic [1:0] MODE_UNSHUFFLE = 2'd2;

  logic [DW-1:0] shuf_data;
  logic [DW-1:0] unshuf_data;
  logic [DW-1:0] reord_data;

  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          in_ready_q, in_ready_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          skid_last_q, skid_last_d;
  logic          in_fire;
  logic          out_fire;

  always_comb begin
    shuf_data   = in_data;
    unshuf_data = in_data;
    for (int i = 0; i < NUM_GROUPS; i++) begin
      for (int j = 0; j < WORDS_PER_GROUP; j++) begin
        shuf_data[(j*NUM_GROUPS + i)*WORD_WIDTH +: WORD_WIDTH] =
          in_data[(i*WORDS_PER_GROUP + j)*WORD_WIDTH +: WORD_WIDTH];
        unshuf_data[(i*WORDS_PER_GROUP + j)*WORD_WIDTH +: WORD_WIDTH] =
          in_data[(j*NUM_GROUPS + i)*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    case (in_mode)
      MODE_SHUFFLE:   reord_data = shuf_data;
      MODE_UNSHUFFLE: reord_data = unshuf_data;
      default:        reord_data = in_data;
    endcase
  end

  always_comb begin
    in_fire      = in_valid & in_ready_q;
    out_fire     = out_valid_q & out_ready;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    if (!out_valid_q || out_fire) begin
      // Skid content is always older than anything arriving this cycle.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) begin
          out_data_d = reord_data;
          out_last_d = in_last;
        end
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = reord_data;
      skid_last_d  = in_last;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    out_data_q  <= out_data_d;
    out_last_q  <= out_last_d;
    skid_data_q <= skid_data_d;
    skid_last_q <= skid_last_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_ad_perfect_shuffle_stream.sv
// Bench for ad_perfect_shuffle_stream: directed scenarios plus randomized traffic
// checked against a word-index reference model and an expected-beat queue.
`timescale 1ns/1ps
module tb_ad_perfect_shuffle_stream;

  localparam int NG  = 2;
  localparam int WPG = 4;
  localparam int WW  = 8;
  localparam int NW  = NG * WPG;
  localparam int DW  = NW * WW;
  localparam int N_RAND  = 10000;
  localparam int MAX_CYC = 60000;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  logic          deg_in_ready;
  logic          deg_out_valid;
  logic [DW-1:0] deg_out_data;
  logic          deg_out_last;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  ad_perfect_shuffle_stream #(.NUM_GROUPS(NG), .WORDS_PER_GROUP(WPG), .WORD_WIDTH(WW)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  ad_perfect_shuffle_stream #(.NUM_GROUPS(1), .WORDS_PER_GROUP(NW), .WORD_WIDTH(WW)) dut_deg (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(deg_in_ready), .in_data(in_data),
    .in_last(in_last), .in_mode(in_mode),
    .out_valid(deg_out_valid), .out_ready(out_ready), .out_data(deg_out_data),
    .out_last(deg_out_last)
  );

  // Reference: for every output word position, find which input word lands there.
  function automatic logic [DW-1:0] ref_model(input logic [DW-1:0] x, input logic [1:0] mode);
    logic [WW-1:0] w [NW];
    logic [DW-1:0] r;
    int src;
    for (int p = 0; p < NW; p++) w[p] = x[p*WW +: WW];
    r = '0;
    for (int p = 0; p < NW; p++) begin
      case (mode)
        2'd1:    src = (p % NG) * WPG + (p / NG);
        2'd2:    src = (p % WPG) * NG + (p / WPG);
        default: src = p;
      endcase
      r[p*WW +: WW] = w[src];
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic [1:0] m, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_last  = l;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    resetn = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_mode = 2'd0; out_ready = 1'b0;
    #1 resetn = 1'b0;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL release_in_ready_pre_edge: got %b need 0", in_ready); end
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready_post_edge: got %b need 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_out_valid: got %b need 0", out_valid); end
  endtask

  task automatic test_modes;
    logic [DW-1:0] mode_exp [4];
    logic [DW-1:0] src;
    src = 64'h0706050403020100;
    mode_exp[0] = 64'h0706050403020100;
    mode_exp[1] = 64'h0703060205010400;
    mode_exp[2] = 64'h0705030106040200;
    mode_exp[3] = 64'h0706050403020100;
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      drive_beat(src, m[1:0], 1'b0);
      step();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mode%0d_latency: out_valid got %b need 1", m, out_valid); end
      n_cmp++; if (out_data !== mode_exp[m]) begin n_err++; $display("FAIL mode%0d_data: got %h need %h", m, out_data, mode_exp[m]); end
      n_cmp++; if (deg_out_data !== src) begin n_err++; $display("FAIL degenerate_mode%0d_data: got %h need %h", m, deg_out_data, src); end
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mode%0d_drained: out_valid got %b need 0", m, out_valid); end
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] d [3];
    logic [1:0]    m [3];
    logic [DW-1:0] e;
    m[0] = 2'd1; m[1] = 2'd2; m[2] = 2'd1;
    for (int k = 0; k < 3; k++) d[k] = {$urandom, $urandom};
    out_ready = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) begin
        e = ref_model(d[k-1], m[k-1]);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid%0d: got %b need 1", k-1, out_valid); end
        n_cmp++; if (out_data !== e) begin n_err++; $display("FAIL b2b_data%0d: got %h need %h", k-1, out_data, e); end
        n_cmp++; if (out_last !== (k == 3)) begin n_err++; $display("FAIL b2b_last%0d: got %b need %b", k-1, out_last, (k == 3)); end
      end
      if (k < 3) drive_beat(d[k], m[k], k == 2);
      else in_valid = 1'b0;
      if (k < 3) step();
    end
    in_last = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: out_valid got %b need 0", out_valid); end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] a, b, c;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    out_ready = 1'b0;
    drive_beat(a, 2'd1, 1'b0);
    step();
    n_cmp++; if (out_data !== ref_model(a, 2'd1)) begin n_err++; $display("FAIL bp_first_loaded: got %h need %h", out_data, ref_model(a, 2'd1)); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_first: got %b need 1", in_ready); end
    drive_beat(b, 2'd2, 1'b0);
    step();
    drive_beat(c, 2'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low%0d: got %b need 0", k, in_ready); end
      n_cmp++; if ({out_valid, out_data} !== {1'b1, ref_model(a, 2'd1)}) begin
        n_err++; $display("FAIL bp_hold%0d: got %b/%h need 1/%h", k, out_valid, out_data, ref_model(a, 2'd1)); end
      if (k < 2) step();
    end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_data !== ref_model(b, 2'd2)) begin n_err++; $display("FAIL bp_drain_second: got %h need %h", out_data, ref_model(b, 2'd2)); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b need 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if ({out_last, out_data} !== {1'b1, c}) begin n_err++; $display("FAIL bp_third: got %b/%h need 1/%h", out_last, out_data, c); end
    step();
    in_last = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle: out_valid got %b need 0", out_valid); end
  endtask

  task automatic test_loopback;
    logic [DW-1:0] x, y;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      x = {$urandom, $urandom};
      drive_beat(x, 2'd1, 1'b0);
      step();
      y = out_data;
      n_cmp++; if ({out_valid, y} !== {1'b1, ref_model(x, 2'd1)}) begin
        n_err++; $display("FAIL loop_shuffle%0d: got %b/%h need 1/%h", n, out_valid, y, ref_model(x, 2'd1)); end
      drive_beat(y, 2'd2, 1'b0);
      step();
      in_valid = 1'b0;
      n_cmp++; if ({out_valid, out_data} !== {1'b1, x}) begin
        n_err++; $display("FAIL loop_restore%0d: got %b/%h need 1/%h", n, out_valid, out_data, x); end
    end
    step();
  endtask

  task automatic test_random;
    int accepted = 0;
    int beats_out = 0;
    int cyc = 0;
    logic prev_hold = 1'b0;
    logic [DW:0] prev_out = '0;
    logic [DW:0] exp;
    exp_q.delete();
    while (beats_out < N_RAND && cyc < MAX_CYC) begin
      step();
      in_valid  = (accepted < N_RAND) && ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      in_mode   = 2'($urandom_range(0, 3));
      in_last   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_hold) begin
        n_cmp++; if ({out_valid, out_last, out_data} !== {1'b1, prev_out}) begin
          n_err++; $display("FAIL rand_stable@%0d: got %b/%h need 1/%h", cyc, out_valid, {out_last, out_data}, prev_out); end
      end
      if (out_valid && out_ready) begin
        beats_out++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_extra_beat@%0d: got %h need no beat", cyc, {out_last, out_data});
        end else begin
          exp = exp_q.pop_front();
          if ({out_last, out_data} !== exp) begin
            n_err++; $display("FAIL rand_beat%0d: got %h need %h", beats_out, {out_last, out_data}, exp); end
        end
      end
      if (in_valid && in_ready) begin
        accepted++;
        exp_q.push_back({in_last, ref_model(in_data, in_mode)});
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_last, out_data};
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (beats_out != N_RAND) begin n_err++; $display("FAIL rand_timeout: got %0d beats need %0d", beats_out, N_RAND); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_leftover: got %0d pending need 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    out_ready = 1'b0;
    drive_beat({$urandom, $urandom}, 2'd1, 1'b0);
    step();
    drive_beat({$urandom, $urandom}, 2'd2, 1'b1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_err++; $display("FAIL rmid_full: got %b need 10", {out_valid, in_ready}); end
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if ({out_valid, in_ready} !== 2'b00) begin n_err++; $display("FAIL rmid_async_clear: got %b need 00", {out_valid, in_ready}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    out_ready = 1'b1;
    step();
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL rmid_release: got %b need 01", {out_valid, in_ready}); end
    drive_beat(d, 2'd0, 1'b0);
    step();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_data} !== {1'b1, d}) begin n_err++; $display("FAIL rmid_new_beat: got %b/%h need 1/%h", out_valid, out_data, d); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_stale: out_valid got %b need 0", out_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_loopback();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
